uart_tx_fifo_drain: RTL and testbench
=====================================

// Module: uart_tx_fifo_drain
// PURPOSE
//   UART transmitter that reads bytes from the TX-side fifo (registered read data,
//   1-cycle read latency) and serialises them onto the tx line as 8N1 frames
//   (optional parity). It is the consumer (reader) end of the fifo. The CPU/host
//   writes the fifo; this block drains it back-to-back while not empty.
// PARAMETERS
//   DATA_WIDTH   8    data bits per frame; must equal the fifo DATA_WIDTH
//   CLKS_PER_BIT 16   clk cycles per serial bit; legal range 2..65535 (16-bit counter)
//   PARITY_EN    0    1 = insert parity bit between last data bit and stop bit
//   PARITY_ODD   0    parity sense when PARITY_EN=1: 0 = even, 1 = odd
// PORTS
//   clk          in   1           system clock, rising edge
//   rst_n        in   1           asynchronous, active-low reset
//   fifo_empty   in   1           fifo empty flag
//   fifo_rd_data in   DATA_WIDTH  fifo read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   out  1           single-cycle read strobe to fifo
//   tx           out  1           serial line, idle high; registered
//   tx_busy      out  1           high whenever state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, tx=1, tx_busy=0, fifo_rd_en=0.
//     Baud counter, bit index and shift register are cleared.
//   Reset asserted mid-frame: the frame is aborted. tx returns to 1 immediately
//     and the byte is lost. No re-read occurs after reset.
//   fifo_rd_en = (state==IDLE) && !fifo_empty (combinational). It is never high
//     outside IDLE, never high when fifo_empty=1, and lasts at most one cycle per byte.
//   FSM states: IDLE, FETCH, START, DATA, PARITY, STOP.
//     IDLE  : tx=1. If !fifo_empty, go to FETCH at the next edge.
//     FETCH : one cycle. Load fifo_rd_data into the shift register, compute parity
//             over it (XOR of data, inverted if PARITY_ODD), go to START.
//             tx=0 is registered on this same edge.
//     START : tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
//     DATA  : tx=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit, shifting
//             right after each bit. After DATA_WIDTH bits, go to PARITY if
//             PARITY_EN, else go to STOP.
//     PARITY: tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
//     STOP  : tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
//   Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
//     It is held at 0 in IDLE and FETCH.
//   Frame length = (1 + DATA_WIDTH + PARITY_EN + 1) * CLKS_PER_BIT cycles of tx
//     activity. Back-to-back bytes leave exactly 2 idle-high cycles (IDLE + FETCH)
//     between the end of one stop bit and the next start bit.
//   Latency: fifo_empty falling while IDLE -> fifo_rd_en the same cycle ->
//     tx falls 2 edges later.
//   fifo_empty is ignored outside IDLE. A fifo write during a frame has no effect
//     until the frame ends.
//   tx_busy is high from entry to FETCH through the last cycle of STOP.
// TESTING (CLKS_PER_BIT=16, DATA_WIDTH=8)
//   1. Reset: rst_n=0 -> tx=1, tx_busy=0, fifo_rd_en=0. Fifo empty after release
//      -> tx stays 1 for 1000 cycles with no rd_en.
//   2. Single byte 0xA5, PARITY_EN=0 -> exactly one rd_en pulse. tx sequence is
//      0,1,0,1,0,0,1,0,1,1, each bit 16 cycles (160 total). tx_busy=0 after.
//   3. Three bytes 0x00, 0xFF, 0x3C queued -> three frames in order, each
//      separated by exactly 2 high cycles. Fifo ends empty. Exactly 3 rd_en pulses.
//   4. PARITY_EN=1: 0xA5 with PARITY_ODD=0 -> parity bit 0; with PARITY_ODD=1
//      -> parity bit 1. Frame is 176 cycles.
//   5. rst_n pulsed low during DATA bit 3 of 0x81 -> tx=1 immediately. No
//      further frame for that byte. The next queued byte is sent cleanly after
//      reset release.
//   6. Fifo written while mid-frame -> no rd_en until STOP ends. The new byte
//      starts 2 cycles after the stop bit ends.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a registered-read fifo into 8N1 frames,
// with an optional parity bit between the last data bit and stop.
module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  tx_busy
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, START, DATA, PARITY, STOP
    } state_t;

    state_t                state;
    logic [15:0]           baud_cnt;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bit;
    logic                  bit_done;

    assign bit_done = (baud_cnt == BAUD_LAST);
    // Gated by rst_n so a held reset never pops the fifo.
    assign fifo_rd_en = rst_n && (state == IDLE) && !fifo_empty;
    assign tx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (!fifo_empty) state <= FETCH;
                end
                FETCH: begin
                    shift    <= fifo_rd_data;
                    par_bit  <= (^fifo_rd_data) ^ (PARITY_ODD != 0);
                    tx       <= 1'b0;
                    baud_cnt <= '0;
                    state    <= START;
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: fifo models feed three instances and
// logged tx/rd_en/busy are compared against a frame-timing reference.
module tb_uart_tx_fifo_drain;
    localparam int CPB  = 16;
    localparam int LOGN = 32768;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem0 [256];
    logic [7:0] memp [256];
    int wr0 = 0;
    int rd0 = 0;
    int wrp = 0;
    int rdp = 0;
    logic empty0, emptyp;
    logic [7:0] rdata0 = 8'h00;
    logic [7:0] rdatap = 8'h00;
    assign empty0 = (wr0 == rd0);
    assign emptyp = (wrp == rdp);

    logic rd_en0, tx0, busy0;
    logic rd_en1, tx1, busy1;
    logic rd_en2, tx2, busy2;

    uart_tx_fifo_drain #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty0),
        .fifo_rd_data(rdata0), .fifo_rd_en(rd_en0),
        .tx(tx0), .tx_busy(busy0)
    );
    uart_tx_fifo_drain #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)
    ) u_par_even (
        .clk(clk), .rst_n(rst_n), .fifo_empty(emptyp),
        .fifo_rd_data(rdatap), .fifo_rd_en(rd_en1),
        .tx(tx1), .tx_busy(busy1)
    );
    uart_tx_fifo_drain #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)
    ) u_par_odd (
        .clk(clk), .rst_n(rst_n), .fifo_empty(emptyp),
        .fifo_rd_data(rdatap), .fifo_rd_en(rd_en2),
        .tx(tx2), .tx_busy(busy2)
    );

    // Registered-read fifo models (one-cycle read latency)
    always @(posedge clk) begin
        if (rd_en0) begin
            rdata0 <= mem0[rd0[7:0]];
            rd0    <= rd0 + 1;
        end
        if (rd_en1) begin
            rdatap <= memp[rdp[7:0]];
            rdp    <= rdp + 1;
        end
    end

    int cyc = 0;
    int viol = 0;
    logic [2:0] tlog [LOGN];
    logic [2:0] rlog [LOGN];
    logic [2:0] blog [LOGN];
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            tlog[cyc] <= {tx2, tx1, tx0};
            rlog[cyc] <= {rd_en2, rd_en1, rd_en0};
            blog[cyc] <= {busy2, busy1, busy0};
        end
        if ((rd_en0 && (empty0 || busy0)) || (rd_en1 && (emptyp || busy1)))
            viol <= viol + 1;
        cyc <= cyc + 1;
    end

    int checks = 0;
    int failures = 0;
    int ev_t[$];
    logic [7:0] ev_b[$];

    function automatic int frame_bit(input logic [7:0] b, input int idx,
                                     input int pe, input int po);
        if (idx == 0) return 0;
        if (idx <= 8) return int'(b[idx-1]);
        if (pe != 0 && idx == 9) return int'((^b) ^ (po != 0));
        return 1;
    endfunction

    task automatic push0(input logic [7:0] b);
        @(posedge clk);
        #1;
        mem0[wr0[7:0]] = b;
        ev_b.push_back(b);
        ev_t.push_back(cyc);
        wr0 = wr0 + 1;
    endtask

    task automatic pushp(input logic [7:0] b);
        @(posedge clk);
        #1;
        memp[wrp[7:0]] = b;
        ev_b.push_back(b);
        ev_t.push_back(cyc);
        wrp = wrp + 1;
    endtask

    task automatic mark(output int from);
        ev_t.delete();
        ev_b.delete();
        @(posedge clk);
        #1;
        from = cyc;
    endtask

    // Reference: each byte is read when it is visible and the line is idle;
    // a frame then occupies 2 idle-high cycles plus (10+pe)*CPB bit cycles.
    task automatic model_check(input string name, input int sel,
                               input int from, input int pe, input int po);
        int fl, f, to, ri;
        int r[$];
        int bt, br, bb, ft, fr, fb;
        fl = (10 + pe) * CPB;
        f = from;
        foreach (ev_t[i]) begin
            ri = (ev_t[i] > f) ? ev_t[i] : f;
            r.push_back(ri);
            f = ri + 2 + fl;
        end
        to = f + 8;
        for (int g = 0; g < 20000 && cyc <= to; g++) @(negedge clk);
        #1;
        checks++;
        if (cyc <= to || to >= LOGN) begin
            failures++;
            $display("FAIL %s timeout: cyc=%0d need=%0d", name, cyc, to);
            return;
        end
        bt = 0; br = 0; bb = 0; ft = -1; fr = -1; fb = -1;
        for (int k = from; k < to; k++) begin
            int etx, erd, ebz;
            etx = 1; erd = 0; ebz = 0;
            foreach (r[i]) begin
                int off;
                off = k - r[i] - 2;
                if (k == r[i]) erd = 1;
                if (k >= r[i] + 1 && off < fl) ebz = 1;
                if (off >= 0 && off < fl)
                    etx = frame_bit(ev_b[i], off / CPB, pe, po);
            end
            if (tlog[k][sel] !== etx[0]) begin
                if (bt == 0) ft = k;
                bt++;
            end
            if (rlog[k][sel] !== erd[0]) begin
                if (br == 0) fr = k;
                br++;
            end
            if (blog[k][sel] !== ebz[0]) begin
                if (bb == 0) fb = k;
                bb++;
            end
        end
        if (bt != 0) begin
            failures++;
            $display("FAIL %s tx: %0d bad cycles, first at rel %0d got %b",
                     name, bt, ft - from, tlog[ft][sel]);
        end
        checks++;
        if (br != 0) begin
            failures++;
            $display("FAIL %s rd_en: %0d bad cycles, first at rel %0d got %b",
                     name, br, fr - from, rlog[fr][sel]);
        end
        checks++;
        if (bb != 0) begin
            failures++;
            $display("FAIL %s tx_busy: %0d bad cycles, first at rel %0d got %b",
                     name, bb, fb - from, blog[fb][sel]);
        end
    endtask

    task automatic test_reset();
        int bad_tx, bad_rd;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx got=%b want=1", tx0);
        end
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b want=0", busy0);
        end
        checks++;
        if (rd_en0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_en got=%b want=0", rd_en0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bad_tx = 0;
        bad_rd = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx0 !== 1'b1) bad_tx++;
            if (rd_en0 !== 1'b0) bad_rd++;
        end
        checks++;
        if (bad_tx != 0) begin
            failures++;
            $display("FAIL idle_tx bad_cycles=%0d want=0", bad_tx);
        end
        checks++;
        if (bad_rd != 0) begin
            failures++;
            $display("FAIL idle_rd_en pulses=%0d want=0", bad_rd);
        end
    endtask

    task automatic test_single();
        int from, base;
        base = rd0;
        mark(from);
        push0(8'hA5);
        model_check("single_a5", 0, from, 0, 0);
        checks++;
        if (rd0 - base != 1) begin
            failures++;
            $display("FAIL single_reads got=%0d want=1", rd0 - base);
        end
    endtask

    task automatic test_back_to_back();
        int from, base;
        base = rd0;
        mark(from);
        push0(8'h00);
        push0(8'hFF);
        push0(8'h3C);
        model_check("b2b", 0, from, 0, 0);
        checks++;
        if (rd0 - base != 3 || empty0 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_drain reads=%0d empty=%b want 3/1",
                     rd0 - base, empty0);
        end
    endtask

    task automatic test_parity();
        int from;
        mark(from);
        pushp(8'hA5);
        model_check("parity_even", 1, from, 1, 0);
        model_check("parity_odd", 2, from, 1, 1);
    endtask

    task automatic test_reset_mid();
        int from, t, g;
        mark(from);
        push0(8'h81);
        t = ev_t[0];
        push0(8'h42);
        for (g = 0; g < 1000 && cyc < t + 2 + 4 * CPB + 5; g++)
            @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx0 !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_tx got=%b want=1", tx0);
        end
        checks++;
        if (rd_en0 !== 1'b0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_ctl rd_en=%b busy=%b want 0/0",
                     rd_en0, busy0);
        end
        repeat (3) @(negedge clk);
        ev_t.delete();
        ev_b.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        from = cyc;
        ev_t.push_back(from);
        ev_b.push_back(8'h42);
        model_check("after_reset", 0, from, 0, 0);
    endtask

    task automatic test_midframe();
        int from;
        mark(from);
        push0(8'($urandom));
        repeat ($urandom_range(20, 150)) @(posedge clk);
        push0(8'($urandom));
        model_check("midframe", 0, from, 0, 0);
    endtask

    task automatic test_random();
        int from;
        mark(from);
        for (int i = 0; i < 6; i++) begin
            push0(8'($urandom));
            repeat ($urandom_range(0, 250)) @(posedge clk);
        end
        model_check("random", 0, from, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        test_midframe();
        test_random();
        checks++;
        if (viol != 0 || rd0 != wr0 || rdp != wrp) begin
            failures++;
            $display("FAIL protocol viol=%0d rd0=%0d wr0=%0d rdp=%0d wrp=%0d",
                     viol, rd0, wr0, rdp, wrp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
